starfield_scroll_ctrl: RTL and testbench

Sequencing controller for the 16-bit LFSR starfield generator. It owns the LFSR `enable` and the star-density test, and sits between `hvsync_generator` and the `LFSR` instance in a starfield top. During the visible 256x256 window it steps the LFSR once per pixel. During vertical blank it issues a programmable burst of extra steps, so the field scrolls at a software-selected speed. Speed and density are reconfigured through a valid/ready handshake that is accepted only while the controller is idle in blank.

---
 rtl/starfield_pkg.sv | 9 +
 rtl/starfield_density_mask.sv | 9 +
 rtl/starfield_scroll_ctrl.sv | 82 ++++++++
 tb/tb_starfield_scroll_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/starfield_pkg.sv
// starfield_pkg: shared state type, window constants and density clamp for the starfield controller
package starfield_pkg;
    typedef enum logic [1:0] {ACTIVE, SKIP, HOLD} sf_state_t;
    localparam int SF_WIN_END = 256;
    localparam int SF_MAX_DENSITY = 8;
    function automatic logic [3:0] clamp_density(input logic [3:0] d);
        return (d == 4'd0) ? 4'd1 : (d > 4'(SF_MAX_DENSITY)) ? 4'(SF_MAX_DENSITY) : d;
    endfunction
endpackage

// File: rtl/starfield_density_mask.sv
// starfield_density_mask: decodes a star density into a mask of that many LFSR MSBs
module starfield_density_mask
    import starfield_pkg::*;
(
    input  logic [3:0]  density,
    output logic [15:0] mask
);
    always_comb mask = ~(16'hFFFF >> clamp_density(density));
endmodule

// File: rtl/starfield_scroll_ctrl.sv
// starfield_scroll_ctrl: steps the starfield LFSR per visible pixel plus a speed-sized burst in vblank
module starfield_scroll_ctrl
    import starfield_pkg::*;
#(
    parameter int SPEED_W = 4,
    parameter int DEFAULT_SPEED = 0,
    parameter int DEFAULT_DENSITY = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8:0]         hpos,
    input  logic [8:0]         vpos,
    input  logic [15:0]        lfsr,
    input  logic               cfg_valid,
    input  logic [SPEED_W-1:0] cfg_speed,
    input  logic [3:0]         cfg_density,
    output logic               cfg_ready,
    output logic               lfsr_enable,
    output logic               star_on,
    output logic               frame_tick
);
    sf_state_t state, state_nx;
    logic [SPEED_W-1:0] speed_q, skip_cnt, skip_cnt_nx;
    logic [3:0] density_q;
    logic [15:0] mask;
    logic win_end, frame_start;

    assign win_end = (vpos == 9'(SF_WIN_END)) && (hpos == '0);
    assign frame_start = (vpos == '0) && (hpos == '0);

    starfield_density_mask u_mask (.density(density_q), .mask(mask));

    assign star_on = &(lfsr | ~mask);

    always_comb begin
        state_nx = state;
        skip_cnt_nx = skip_cnt;
        lfsr_enable = 1'b0;
        case (state)
            ACTIVE: begin
                lfsr_enable = ~hpos[8] & ~vpos[8];
                if (win_end) begin
                    state_nx = (speed_q == '0) ? HOLD : SKIP;
                    skip_cnt_nx = speed_q;
                end
            end
            SKIP: begin
                lfsr_enable = 1'b1;
                skip_cnt_nx = skip_cnt - 1'b1;
                // a new frame arriving mid-burst wins over the remaining steps
                if (vpos == '0) begin
                    state_nx = ACTIVE;
                    skip_cnt_nx = '0;
                end else if (skip_cnt <= SPEED_W'(1)) begin
                    state_nx = HOLD;
                end
            end
            HOLD: state_nx = frame_start ? ACTIVE : HOLD;
            default: state_nx = ACTIVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACTIVE;
            speed_q <= SPEED_W'(DEFAULT_SPEED);
            density_q <= clamp_density(4'(DEFAULT_DENSITY));
            skip_cnt <= '0;
            frame_tick <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            state <= state_nx;
            skip_cnt <= skip_cnt_nx;
            frame_tick <= (state == ACTIVE) && (state_nx != ACTIVE);
            cfg_ready <= (state_nx == HOLD);
            if (cfg_valid && cfg_ready) begin
                speed_q <= cfg_speed;
                density_q <= clamp_density(cfg_density);
            end
        end
    end
endmodule

// File: tb/tb_starfield_scroll_ctrl.sv
// tb_starfield_scroll_ctrl: randomized frame-level checks of the starfield scroll controller
module tb_starfield_scroll_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic [8:0] hpos, vpos;
    logic [15:0] lfsr;
    logic cfg_valid;
    logic [3:0] cfg_speed, cfg_density;
    logic cfg_ready, lfsr_enable, star_on, frame_tick;

    int checks = 0;
    int passes = 0;
    int m_speed, m_density;
    bit pend = 1'b0;
    int pend_speed = 0, pend_density = 7;

    always #5 clk = ~clk;

    starfield_scroll_ctrl dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .lfsr(lfsr),
        .cfg_valid(cfg_valid), .cfg_speed(cfg_speed), .cfg_density(cfg_density),
        .cfg_ready(cfg_ready), .lfsr_enable(lfsr_enable), .star_on(star_on), .frame_tick(frame_tick)
    );

    function automatic int clamp(input int d);
        return (d == 0) ? 1 : (d > 8) ? 8 : d;
    endfunction

    // a star needs the top d bits of the LFSR to all be ones
    function automatic bit star_ref(input logic [15:0] v, input int d);
        return (int'(v) >> (16 - d)) == ((1 << d) - 1);
    endfunction

    task automatic drive(input int h, input int v);
        hpos = 9'(h);
        vpos = 9'(v);
        lfsr = ($urandom_range(0, 3) == 0) ? ~16'($urandom_range(0, 511)) : 16'($urandom);
        cfg_valid = pend;
        cfg_speed = 4'(pend_speed);
        cfg_density = 4'(pend_density);
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // one frame: vis window cycles, the (256,0) cycle, then blank cycles ending at (0,0)
    task automatic run_frame(input int vis, input int blank, output int got_en, output int want_en, output int acc_k);
        int spd, h, v, k;
        bit ew, et, er, es;
        got_en = 0;
        want_en = 0;
        acc_k = -1;
        spd = m_speed;
        for (int c = 0; c <= vis + blank; c++) begin
            k = c - vis;
            if (k < 0) begin
                h = $urandom_range(0, 308);
                v = $urandom_range(0, 255);
            end else if (k == 0) begin
                h = 0;
                v = 256;
                spd = m_speed;
            end else if (k == blank) begin
                h = 0;
                v = 0;
            end else begin
                h = $urandom_range(0, 308);
                v = $urandom_range(256, 261);
            end
            drive(h, v);
            ew = (k < 0) ? (h < 256) : (k >= 1 && k <= spd);
            et = (k == 1);
            er = (k >= 1 && k > spd);
            es = star_ref(lfsr, m_density);
            want_en += int'(ew);
            got_en += int'(lfsr_enable);
            checks++;
            if (lfsr_enable !== ew) $display("FAIL frame_enable k=%0d got %b want %b", k, lfsr_enable, ew);
            else passes++;
            checks++;
            if (frame_tick !== et) $display("FAIL frame_tick k=%0d got %b want %b", k, frame_tick, et);
            else passes++;
            checks++;
            if (cfg_ready !== er) $display("FAIL frame_ready k=%0d got %b want %b", k, cfg_ready, er);
            else passes++;
            checks++;
            if (star_on !== es) $display("FAIL frame_star lfsr=%h d=%0d got %b want %b", lfsr, m_density, star_on, es);
            else passes++;
            if (pend && er) begin
                m_speed = pend_speed;
                m_density = clamp(pend_density);
                pend = 1'b0;
                acc_k = k;
            end
            advance();
        end
    endtask

    task automatic configure(input int sp, input int dn);
        int g, w, a;
        pend = 1'b1;
        pend_speed = sp;
        pend_density = dn;
        run_frame(8, 18, g, w, a);
        checks++;
        if (g !== w) $display("FAIL cfg_frame_enables got %0d want %0d", g, w);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        hpos = '0;
        vpos = '0;
        lfsr = 16'hFE00;
        cfg_valid = 1'b0;
        cfg_speed = '0;
        cfg_density = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) $display("FAIL reset_tick got %b want 0", frame_tick);
        else passes++;
        checks++;
        if (cfg_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", cfg_ready);
        else passes++;
        checks++;
        if (lfsr_enable !== 1'b1) $display("FAIL reset_enable got %b want 1", lfsr_enable);
        else passes++;
        checks++;
        if (star_on !== 1'b1) $display("FAIL reset_star_fe00 got %b want 1", star_on);
        else passes++;
        lfsr = 16'hFC00;
        #1;
        checks++;
        if (star_on !== 1'b0) $display("FAIL reset_star_fc00 got %b want 0", star_on);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_speed = 0;
        m_density = 7;
        pend = 1'b0;
    endtask

    task automatic test_default_frame();
        int g, w, a;
        run_frame(48, 20, g, w, a);
        checks++;
        if (g !== w) $display("FAIL default_enables got %0d want %0d", g, w);
        else passes++;
    endtask

    task automatic test_speed();
        int g, w, a, vis_en;
        pend = 1'b1;
        pend_speed = 5;
        pend_density = 7;
        run_frame(40, 20, g, w, a);
        checks++;
        if (a !== 1) $display("FAIL speed_accept_k got %0d want 1", a);
        else passes++;
        run_frame(40, 20, g, w, a);
        vis_en = w - 5;
        checks++;
        if (g !== vis_en + 5) $display("FAIL speed_enables got %0d want %0d", g, vis_en + 5);
        else passes++;
    endtask

    task automatic test_density();
        int dens[6] = '{7, 7, 0, 0, 12, 12};
        logic [15:0] vals[6] = '{16'hFE00, 16'hFC00, 16'h8000, 16'h7FFF, 16'hFF00, 16'hFEFF};
        bit want[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) configure(m_speed, dens[i]);
            drive(10, 10);
            lfsr = vals[i];
            #1;
            checks++;
            if (star_on !== want[i]) $display("FAIL density_%0d lfsr=%h got %b want %b", dens[i], vals[i], star_on, want[i]);
            else passes++;
            advance();
        end
    endtask

    task automatic test_hold_valid();
        int g, w, a, old;
        old = m_speed;
        pend = 1'b1;
        pend_speed = $urandom_range(1, 15);
        pend_density = $urandom_range(0, 15);
        run_frame(30, 20, g, w, a);
        checks++;
        if (a !== old + 1) $display("FAIL hold_accept_k got %0d want %0d", a, old + 1);
        else passes++;
        run_frame(30, 20, g, w, a);
        checks++;
        if (g !== w) $display("FAIL hold_next_enables got %0d want %0d", g, w);
        else passes++;
    endtask

    task automatic test_reset_mid_skip();
        int g, w, a;
        configure(7, 3);
        for (int i = 0; i < 4; i++) begin
            drive(i * 20, 30);
            advance();
        end
        drive(0, 256);
        advance();
        for (int k = 1; k <= 4; k++) begin
            drive(k, 257);
            advance();
        end
        drive(3, 257);
        checks++;
        if (lfsr_enable !== 1'b1) $display("FAIL skip_before_reset got %b want 1", lfsr_enable);
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (lfsr_enable !== 1'b0) $display("FAIL rst_skip_enable_blank got %b want 0", lfsr_enable);
        else passes++;
        checks++;
        if (frame_tick !== 1'b0) $display("FAIL rst_skip_tick got %b want 0", frame_tick);
        else passes++;
        checks++;
        if (cfg_ready !== 1'b0) $display("FAIL rst_skip_ready got %b want 0", cfg_ready);
        else passes++;
        hpos = 9'd20;
        vpos = 9'd20;
        #1;
        checks++;
        if (lfsr_enable !== 1'b1) $display("FAIL rst_skip_enable_window got %b want 1", lfsr_enable);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_speed = 0;
        m_density = 7;
        pend = 1'b0;
        run_frame(20, 20, g, w, a);
        checks++;
        if (g !== w) $display("FAIL rst_skip_next_enables got %0d want %0d", g, w);
        else passes++;
    endtask

    task automatic test_vpos_abort();
        int g, w, a;
        configure(10, 7);
        for (int i = 0; i < 5; i++) begin
            drive(i * 30, 40);
            advance();
        end
        drive(0, 256);
        advance();
        for (int k = 1; k <= 3; k++) begin
            drive(k * 7, 258);
            checks++;
            if (lfsr_enable !== 1'b1) $display("FAIL abort_burst_%0d got %b want 1", k, lfsr_enable);
            else passes++;
            advance();
        end
        drive(5, 0);
        checks++;
        if (lfsr_enable !== 1'b1) $display("FAIL abort_last_skip got %b want 1", lfsr_enable);
        else passes++;
        advance();
        for (int i = 0; i < 6; i++) begin
            drive(260 + i, i);
            checks++;
            if (lfsr_enable !== 1'b0) $display("FAIL abort_no_burst_%0d got %b want 0", i, lfsr_enable);
            else passes++;
            checks++;
            if (cfg_ready !== 1'b0) $display("FAIL abort_ready_%0d got %b want 0", i, cfg_ready);
            else passes++;
            advance();
        end
        drive(7, 1);
        checks++;
        if (lfsr_enable !== 1'b1) $display("FAIL abort_active got %b want 1", lfsr_enable);
        else passes++;
        advance();
        run_frame(20, 20, g, w, a);
        checks++;
        if (g !== w) $display("FAIL abort_next_enables got %0d want %0d", g, w);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int g, w, a;
        for (int f = 0; f < 5; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                pend = 1'b1;
                pend_speed = $urandom_range(0, 15);
                pend_density = $urandom_range(0, 15);
            end
            run_frame($urandom_range(10, 40), $urandom_range(17, 25), g, w, a);
            checks++;
            if (g !== w) $display("FAIL b2b_enables_%0d got %0d want %0d", f, g, w);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_speed();
        test_density();
        test_hold_valid();
        test_reset_mid_skip();
        test_vpos_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
